// File: rtl/yarvi_bus_pkg.sv
// Shared types for the yarvi memory-bus arbiter: requester source tag and FIFO entry layout.
package yarvi_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_t;

  typedef struct packed {
    src_t src;
    logic discard;
  } tag_t;

  function automatic tag_t mk_tag(input src_t s);
    tag_t t;
    t.src     = s;
    t.discard = 1'b0;
    return t;
  endfunction

endpackage

// File: rtl/yarvi_bus_arb_if.sv
// Valid/ready request channel with an in-order response return path.
interface yarvi_bus_arb_if
  import yarvi_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic                valid;
  logic                write;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wmask;
  logic                ready;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_data;

  modport master (
    output valid, write, addr, wdata, wmask,
    input  ready, rsp_valid, rsp_data
  );

  modport slave (
    input  valid, write, addr, wdata, wmask,
    output ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/yarvi_tag_fifo.sv
// In-order tag FIFO recording the originator of each outstanding bus transaction.
module yarvi_tag_fifo
  import yarvi_bus_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  tag_t                     push_tag,
  input  logic                     pop,
  input  logic                     flush_i,
  output tag_t                     head,
  output logic [$clog2(MAX_OUT):0] count,
  output logic                     full
);

  localparam int PTR_W = $clog2(MAX_OUT);

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  tag_t             mem [MAX_OUT];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Flush marks stale fetch slots; an entry pushed in the same cycle overrides with discard=0.
  always_ff @(posedge clock) begin
    for (int i = 0; i < MAX_OUT; i++) begin
      if (flush_i && mem[i].src == SRC_I) mem[i].discard <= 1'b1;
    end
    if (push) mem[wptr] <= push_tag;
  end

  assign head = mem[rptr];
  assign full = (count == (PTR_W+1)'(MAX_OUT));

endmodule

// File: rtl/yarvi_bus_arb.sv
// Shares one memory bus between fetch and data ports; steers in-order responses back by tag.
module yarvi_bus_arb
  import yarvi_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_OUT    = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic             clock,
  input  logic             reset,
  yarvi_bus_arb_if.slave   fetch,
  input  logic             i_flush,
  yarvi_bus_arb_if.slave   data,
  yarvi_bus_arb_if.master  bus,
  output logic             err_orphan
);

  localparam int SC_W = $clog2(STARVE_LIM + 1);

  logic [SC_W-1:0]          starve_cnt;
  logic [$clog2(MAX_OUT):0] count;
  logic                     full;
  logic                     empty;
  logic                     can_issue;
  logic                     starved;
  logic                     grant_i;
  logic                     accept_i;
  logic                     accept_d;
  logic                     push;
  logic                     pop;
  tag_t                     head;

  assign empty     = (count == '0);
  assign can_issue = ~full;
  assign starved   = (starve_cnt == SC_W'(STARVE_LIM));
  assign grant_i   = fetch.valid & (~data.valid | starved);

  always_comb begin
    bus.valid   = can_issue & (fetch.valid | data.valid);
    bus.write   = data.write;
    bus.addr    = data.addr;
    bus.wdata   = data.wdata;
    bus.wmask   = data.wmask;
    if (grant_i) begin
      bus.write = 1'b0;
      bus.addr  = ADDR_W'(fetch.addr);
      bus.wdata = DATA_W'(0);
      bus.wmask = (DATA_W/8)'(0);
    end
    fetch.ready = can_issue & bus.ready & grant_i;
    data.ready  = can_issue & bus.ready & data.valid & ~grant_i;
  end

  assign accept_i = fetch.valid & fetch.ready;
  assign accept_d = data.valid & data.ready;
  assign push     = accept_i | accept_d;
  assign pop      = bus.rsp_valid & ~empty;

  yarvi_tag_fifo #(.MAX_OUT(MAX_OUT)) u_tags (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_tag (mk_tag(accept_i ? SRC_I : SRC_D)),
    .pop      (pop),
    .flush_i  (i_flush),
    .head     (head),
    .count    (count),
    .full     (full)
  );

  // A fetch response popping during a flush is as stale as the ones still queued.
  always_comb begin
    fetch.rsp_valid = pop & (head.src == SRC_I) & ~head.discard & ~i_flush;
    fetch.rsp_data  = bus.rsp_data;
    data.rsp_valid  = pop & (head.src == SRC_D);
    data.rsp_data   = bus.rsp_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!fetch.valid || accept_i) begin
      starve_cnt <= '0;
    end else if (accept_d && !starved) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_orphan <= 1'b0;
    end else if (bus.rsp_valid && empty) begin
      err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_yarvi_bus_arb.sv
// Scoreboard bench for yarvi_bus_arb: expected responses queued per requester at accept time.
module tb_yarvi_bus_arb;
  import yarvi_bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic i_flush = 1'b0;
  logic err_orphan;

  yarvi_bus_arb_if #(.ADDR_W(AW), .DATA_W(DW)) fi ();
  yarvi_bus_arb_if #(.ADDR_W(AW), .DATA_W(DW)) di ();
  yarvi_bus_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bi ();

  yarvi_bus_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(4), .STARVE_LIM(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .fetch      (fi),
    .i_flush    (i_flush),
    .data       (di),
    .bus        (bi),
    .err_orphan (err_orphan)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_i [$];
  logic [DW-1:0] exp_d [$];
  logic [7:0]    grant_d_tbl;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic respond(input logic [DW-1:0] d);
    bi.rsp_valid = 1'b1;
    bi.rsp_data  = d;
    sample();
    tick();
    bi.rsp_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (fi.rsp_valid) begin
        if (exp_i.size() == 0) check("i_rsp_unexpected", fi.rsp_valid, 1'b0);
        else                   check("i_rsp_data", fi.rsp_data, exp_i.pop_front());
      end
      if (di.rsp_valid) begin
        if (exp_d.size() == 0) check("d_rsp_unexpected", di.rsp_valid, 1'b0);
        else                   check("d_rsp_data", di.rsp_data, exp_d.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    fi.valid = 0; fi.write = 0; fi.addr = '0; fi.wdata = '0; fi.wmask = '0;
    di.valid = 0; di.write = 0; di.addr = '0; di.wdata = '0; di.wmask = '0;
    bi.ready = 0; bi.rsp_valid = 0; bi.rsp_data = '0;
    grant_d_tbl = 8'b0111_0111;

    #2;
    check("rst_i_ready", fi.ready, 0);
    check("rst_d_ready", di.ready, 0);
    check("rst_i_rsp", fi.rsp_valid, 0);
    check("rst_d_rsp", di.rsp_valid, 0);
    check("rst_err", err_orphan, 0);
    tick();
    reset = 0;
    bi.ready = 1;

    // single fetch read, then single store
    fi.valid = 1; fi.addr = 32'h100;
    sample();
    check("rd_bus_valid", bi.valid, 1);
    check("rd_bus_addr", bi.addr, 32'h100);
    check("rd_bus_write", bi.write, 0);
    check("rd_bus_wmask", bi.wmask, 0);
    check("rd_i_ready", fi.ready, 1);
    check("rd_d_ready", di.ready, 0);
    exp_i.push_back(32'hDEADBEEF);
    tick();
    fi.valid = 0;
    respond(32'hDEADBEEF);

    di.valid = 1; di.write = 1; di.addr = 32'h200; di.wdata = 32'hFF00FF00; di.wmask = 4'hF;
    sample();
    check("st_bus_write", bi.write, 1);
    check("st_bus_addr", bi.addr, 32'h200);
    check("st_bus_wdata", bi.wdata, 32'hFF00FF00);
    check("st_bus_wmask", bi.wmask, 4'hF);
    check("st_d_ready", di.ready, 1);
    check("st_i_ready", fi.ready, 0);
    exp_d.push_back(32'h0);
    tick();
    di.valid = 0; di.write = 0; di.wmask = '0; di.wdata = '0;
    respond(32'h0);

    // both requesters continuously valid: starvation limit forces every fourth grant to fetch
    fi.addr = 32'h300; di.addr = 32'h500;
    for (int k = 0; k < 8; k++) begin
      fi.valid = 1; di.valid = 1;
      if (k > 0) begin
        bi.rsp_valid = 1;
        bi.rsp_data  = 32'h1000 + DW'(k - 1);
      end
      sample();
      check("arb_d_ready", di.ready, grant_d_tbl[k]);
      check("arb_i_ready", fi.ready, !grant_d_tbl[k]);
      check("arb_both_ready", fi.ready & di.ready, 0);
      check("arb_bus_addr", bi.addr, grant_d_tbl[k] ? 32'h500 : 32'h300);
      if (grant_d_tbl[k]) exp_d.push_back(32'h1000 + DW'(k));
      else                exp_i.push_back(32'h1000 + DW'(k));
      tick();
    end
    fi.valid = 0; di.valid = 0;
    respond(32'h1007);

    // fill to MAX_OUT outstanding
    fi.valid = 1;
    for (int n = 0; n < 4; n++) begin
      fi.addr = 32'h600 + AW'(4 * n);
      sample();
      check("fill_i_ready", fi.ready, 1);
      exp_i.push_back(32'h2000 + DW'(n));
      tick();
    end
    fi.addr = 32'h610; di.valid = 1;
    sample();
    check("full_i_ready", fi.ready, 0);
    check("full_d_ready", di.ready, 0);
    check("full_bus_valid", bi.valid, 0);
    tick();
    di.valid = 0;
    bi.rsp_valid = 1; bi.rsp_data = 32'h2000;
    sample();
    check("full_pop_i_ready", fi.ready, 0);
    tick();
    bi.rsp_valid = 0;
    sample();
    check("after_pop_i_ready", fi.ready, 1);
    exp_i.push_back(32'h2004);
    tick();
    fi.addr = 32'h614;
    sample();
    check("refull_i_ready", fi.ready, 0);
    tick();
    fi.valid = 0;
    for (int n = 1; n <= 4; n++) respond(32'h2000 + DW'(n));

    // flush with I,I,D outstanding while accepting the restart fetch
    fi.valid = 1; fi.addr = 32'h10;
    sample(); check("fl_i0_ready", fi.ready, 1); tick();
    fi.addr = 32'h14;
    sample(); check("fl_i1_ready", fi.ready, 1); tick();
    fi.valid = 0; di.valid = 1; di.addr = 32'h20;
    sample(); check("fl_d_ready", di.ready, 1);
    exp_d.push_back(32'h3002);
    tick();
    di.valid = 0;
    i_flush = 1; fi.valid = 1; fi.addr = 32'h400;
    sample();
    check("flush_i_ready", fi.ready, 1);
    check("flush_bus_addr", bi.addr, 32'h400);
    exp_i.push_back(32'h3003);
    tick();
    i_flush = 0; fi.valid = 0;
    for (int n = 0; n < 4; n++) begin
      bi.rsp_valid = 1; bi.rsp_data = 32'h3000 + DW'(n);
      sample();
      if (n < 2) check("flushed_i_rsp", fi.rsp_valid, 0);
      tick();
    end
    bi.rsp_valid = 0;

    // flush in the same cycle the fetch response pops
    fi.valid = 1; fi.addr = 32'h40;
    sample(); tick();
    fi.valid = 0;
    bi.rsp_valid = 1; bi.rsp_data = 32'h3100; i_flush = 1;
    sample();
    check("flush_pop_i_rsp", fi.rsp_valid, 0);
    tick();
    bi.rsp_valid = 0; i_flush = 0;

    // orphan response
    sample();
    check("orphan_pre_err", err_orphan, 0);
    tick();
    bi.rsp_valid = 1; bi.rsp_data = 32'hBAD;
    sample();
    check("orphan_i_rsp", fi.rsp_valid, 0);
    check("orphan_d_rsp", di.rsp_valid, 0);
    tick();
    bi.rsp_valid = 0;
    sample();
    check("orphan_err", err_orphan, 1);
    repeat (3) tick();
    sample();
    check("orphan_err_sticky", err_orphan, 1);
    tick();

    // async reset with three data transactions outstanding
    di.valid = 1; di.addr = 32'h700;
    repeat (3) tick();
    di.valid = 0;
    @(posedge clock);
    #3;
    reset = 1;
    #1;
    check("arst_i_ready", fi.ready, 0);
    check("arst_d_ready", di.ready, 0);
    check("arst_i_rsp", fi.rsp_valid, 0);
    check("arst_d_rsp", di.rsp_valid, 0);
    check("arst_bus_valid", bi.valid, 0);
    check("arst_err", err_orphan, 0);
    tick();
    reset = 0;
    fi.valid = 1; fi.addr = 32'h800;
    sample();
    check("post_rst_i_ready", fi.ready, 1);
    exp_i.push_back(32'h4000);
    tick();
    fi.valid = 0;
    bi.rsp_valid = 1; bi.rsp_data = 32'h4000;
    sample();
    check("post_rst_i_rsp", fi.rsp_valid, 1);
    check("post_rst_d_rsp", di.rsp_valid, 0);
    tick();
    bi.rsp_valid = 0;
    sample();
    check("post_rst_err", err_orphan, 0);

    check("i_queue_empty", exp_i.size(), 0);
    check("d_queue_empty", exp_d.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/yarvi_bus_arb.md
# yarvi_bus_arb

Two-requester arbiter that shares one memory bus between the fetch stage's code-read port and the memory stage's data load/store port. It sits between yarvi_fe/yarvi_me and the external memory, accepts requests with valid/ready handshakes and tracks up to MAX_OUT in-order outstanding transactions. It steers each bus response back to its originator and discards stale fetch responses after a pipeline restart.

## Interface
Parameters:
- ADDR_W, 32: byte-address width.
- DATA_W, 32: bus data width.
- MAX_OUT, 4: maximum outstanding transactions; power of two, ≥2.
- STARVE_LIM, 3: consecutive data grants allowed while fetch waits.

Ports (clock, reset: one clock; reset is asynchronous, active-high):
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- i_valid  in  1  fetch read request.
- i_addr  in  ADDR_W  fetch address.
- i_ready  out  1  fetch request accepted this cycle.
- i_flush  in  1  restart; discard all outstanding fetch responses.
- i_rsp_valid  out  1  fetch response valid.
- i_rsp_data  out  DATA_W  fetch response data.
- d_valid  in  1  data request.
- d_write  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_wmask  in  DATA_W/8  byte enables.
- d_ready  out  1  data request accepted.
- d_rsp_valid  out  1  data response (load data or store ack).
- d_rsp_data  out  DATA_W  load data; undefined for store acks.
- bus_valid, bus_write, bus_addr, bus_wdata, bus_wmask  out  —  downstream request.
- bus_ready  in  1  downstream accepts request.
- bus_rsp_valid  in  1  downstream response, strictly in request order.
- bus_rsp_data  in  DATA_W  response data.
- err_orphan  out  1  sticky: response arrived with nothing outstanding.

## Operation
- Every accepted request, read or write, yields exactly one bus response, in order.
- Tag FIFO, MAX_OUT deep. Entry = {src (I/D), discard}. Push on accept, pop on bus_rsp_valid.
- `can_issue` = count < MAX_OUT. When full, no request is accepted, even if a response pops in the same cycle.
- Arbitration is combinational each cycle:
  - Data has priority over fetch.
  - Fetch wins if `starve_cnt` == STARVE_LIM and i_valid is high.
  - `starve_cnt` increments on a D accept while i_valid is high. It clears on any I accept, or when i_valid is low. It saturates at STARVE_LIM.
- bus_valid = can_issue & (i_valid | d_valid). Bus request fields are muxed from the winner. Fetch drives bus_write=0 and bus_wmask=0.
- i_ready = can_issue & bus_ready & grant_i. d_ready is the analogue. They are never both high.
- Response routing uses the FIFO head:
  - i_rsp_valid = bus_rsp_valid & head.src==I & !head.discard.
  - d_rsp_valid = bus_rsp_valid & head.src==D.
  - Both rsp_data outputs equal bus_rsp_data.
- i_flush sets discard on every I entry present in the FIFO that cycle, including one popping that cycle.
  - An I request accepted in the flush cycle is pushed with discard=0, so the restart-PC fetch survives.
  - D entries are never discarded.
- A discarded response is popped silently. Neither rsp_valid asserts.
- bus_rsp_valid with count==0: ignored, and err_orphan is set until reset.
- Simultaneous push and pop: count unchanged, FIFO pointers both advance.

## Timing
- Zero added latency both ways. Request-to-bus and response-to-requester paths are combinational.
- Accept occurs on the rising edge with valid & ready. The FIFO entry is visible from the next cycle.
- A response may arrive in the cycle after accept at the earliest; same-cycle responses are not supported.
- Reset (async) clears:
  - FIFO pointers and count → 0.
  - starve_cnt → 0.
  - err_orphan → 0.
  - All ready and rsp_valid outputs → 0, since count 0 and valid inputs are deasserted during reset.
- Reset mid-transaction drops all tags. The downstream must also be reset. Later stray responses raise err_orphan.

## Structure
- Package yarvi_bus_pkg:
  - src_t enum {SRC_I, SRC_D}.
  - tag_t struct {src, discard}.
  - Shared width localparams.
- Sub-module yarvi_tag_fifo: MAX_OUT-entry tag FIFO with push, pop, count and full, plus a flush-I port that sets the discard bits in parallel.
- yarvi_bus_arb holds the arbitration mux, starvation counter, response steering and error flag.

## Test plan
- Alternate single reads: I@0x100 → bus_addr=0x100, i_rsp_valid with data 0xDEADBEEF; then D store 0x200/0xFF00FF00/mask 0xF → bus_write=1, d_rsp_valid ack.
- Both requesters valid continuously, bus_ready=1, STARVE_LIM=3, MAX_OUT large enough not to fill → grant order D,D,D,I,D,D,D,I; no cycle has both readies high.
- Issue 4 reads with no responses → 5th request sees i_ready=d_ready=0. One response plus a new request in the same cycle → new request not accepted; it is accepted the next cycle, and count returns to 4.
- Outstanding I,I,D, assert i_flush while also accepting I@0x400 → both old I responses suppressed, D response delivered, 0x400 response delivered on i_rsp_valid.
- bus_rsp_valid with FIFO empty → no rsp_valid, err_orphan=1 until reset.
- Assert reset asynchronously with 3 outstanding → count=0, all outputs low immediately; after release a fresh I read completes normally.
